// File: rtl/hdc_assoc_search_if.sv
// Query/ROM/result bundle for the HDC associative-search stage.
// master: search stage side; slave: query source, ROM and result sink.
interface hdc_assoc_search_if #(
  parameter int FRAME_WIDTH = 64,
  parameter int CLASS_W     = 3,
  parameter int FIDX_W      = 2,
  parameter int DIST_W      = 8
);
  logic                   q_valid;
  logic                   q_ready;
  logic [FRAME_WIDTH-1:0] q_frame;
  logic [CLASS_W-1:0]     frame_id;
  logic [FIDX_W-1:0]      frame_index;
  logic [FRAME_WIDTH-1:0] class_vec_in;
  logic                   res_valid;
  logic                   res_ready;
  logic [CLASS_W-1:0]     res_class;
  logic [DIST_W-1:0]      res_dist;

  modport master (
    input  q_valid, q_frame, class_vec_in, res_ready,
    output q_ready, frame_id, frame_index,
    output res_valid, res_class, res_dist
  );

  modport slave (
    output q_valid, q_frame, class_vec_in, res_ready,
    input  q_ready, frame_id, frame_index,
    input  res_valid, res_class, res_dist
  );
endinterface

// File: rtl/hdc_assoc_search.sv
// Buffers a query hypervector, sweeps class_vec_gen, reports min-Hamming class.
// Ports: clk, rst (sync, active-high), bus (hdc_assoc_search_if.master).
module hdc_assoc_search #(
  parameter int FRAME_WIDTH = 64,
  parameter int NUM_FRAMES  = 3,
  parameter int NUM_CLASSES = 8,
  parameter int CLASS_W     = 3,
  parameter int FIDX_W      = 2,
  parameter int DIST_W      = 8
) (
  input logic              clk,
  input logic              rst,
  hdc_assoc_search_if.master bus
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SEARCH,
    S_DONE
  } state_t;

  localparam logic [FIDX_W-1:0] LAST_F =
    FIDX_W'(NUM_FRAMES - 1);
  localparam logic [CLASS_W-1:0] LAST_C =
    CLASS_W'(NUM_CLASSES - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [FIDX_W-1:0]      r_load_cnt;
  logic [FRAME_WIDTH-1:0] r_qbuf [NUM_FRAMES];
  logic [CLASS_W-1:0]     r_cls;
  logic [FIDX_W-1:0]      r_fidx;
  logic [DIST_W-1:0]      r_acc;
  logic [DIST_W-1:0]      r_best_dist;
  logic [CLASS_W-1:0]     r_best_class;

  logic [FRAME_WIDTH-1:0] w_x;
  logic [DIST_W-1:0]      w_pop;
  logic [DIST_W-1:0]      w_dist;
  logic                   w_last_f;
  logic                   w_q_acc;

  assign w_last_f = (r_fidx == LAST_F);
  assign w_q_acc  = (r_state == S_LOAD) &&
                    bus.q_valid && !rst;

  // ROM data arrives in the same cycle as the address.
  always_comb begin
    w_x   = r_qbuf[r_fidx] ^ bus.class_vec_in;
    w_pop = '0;
    for (int i = 0; i < FRAME_WIDTH; i++)
      w_pop = w_pop + DIST_W'(w_x[i]);
    w_dist = r_acc + w_pop;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD:
        if (bus.q_valid && r_load_cnt == LAST_F)
          w_next = S_SEARCH;
      S_SEARCH:
        if (r_cls == LAST_C && w_last_f)
          w_next = S_DONE;
      S_DONE:
        if (bus.res_ready)
          w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  // Outputs are forced low during reset so nothing
  // leaks out before the state register settles.
  always_comb begin
    bus.q_ready     = 1'b0;
    bus.frame_id    = '0;
    bus.frame_index = '0;
    bus.res_valid   = 1'b0;
    bus.res_class   = '0;
    bus.res_dist    = '0;
    if (!rst) begin
      unique case (r_state)
        S_LOAD: bus.q_ready = 1'b1;
        S_SEARCH: begin
          bus.frame_id    = r_cls;
          bus.frame_index = r_fidx;
        end
        S_DONE: begin
          bus.res_valid = 1'b1;
          bus.res_class = r_best_class;
          bus.res_dist  = r_best_dist;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_q_acc)
      r_qbuf[r_load_cnt] <= bus.q_frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_cnt   <= '0;
      r_cls        <= '0;
      r_fidx       <= '0;
      r_acc        <= '0;
      r_best_dist  <= '0;
      r_best_class <= '0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (bus.q_valid) begin
            r_load_cnt <= r_load_cnt + FIDX_W'(1);
            if (r_load_cnt == LAST_F) begin
              r_cls        <= '0;
              r_fidx       <= '0;
              r_acc        <= '0;
              r_best_dist  <= '1;
              r_best_class <= '0;
            end
          end
        end
        S_SEARCH: begin
          if (!w_last_f) begin
            r_acc  <= w_dist;
            r_fidx <= r_fidx + FIDX_W'(1);
          end else begin
            // Strict compare: ties keep the lower class.
            if (w_dist < r_best_dist) begin
              r_best_dist  <= w_dist;
              r_best_class <= r_cls;
            end
            r_acc  <= '0;
            r_fidx <= '0;
            r_cls  <= r_cls + CLASS_W'(1);
          end
        end
        S_DONE: begin
          if (bus.res_ready)
            r_load_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hdc_assoc_search.md
# hdc_assoc_search

Associative-search stage for the HDC inference path. It buffers one query hypervector delivered as NUM_FRAMES frames of FRAME_WIDTH bits. It then sweeps the class-vector generator by driving its `frame_id`/`frame_index` address and consuming the returned frame. For every class it accumulates the Hamming distance, and it reports the class with the minimum distance through a valid/ready result port. It sits directly downstream of `class_vec_gen`, which it addresses combinationally.

## Interface
- FRAME_WIDTH, 64: bits per frame.
- NUM_FRAMES, 3: frames per hypervector (dimension = 192).
- NUM_CLASSES, 8: number of classes swept.
- CLASS_W, 3: width of the class id.
- FIDX_W, 2: width of the frame index.
- DIST_W, 8: distance width; must satisfy 2^DIST_W > FRAME_WIDTH*NUM_FRAMES.

- clk  in  1  clock; single clock domain, rising edge.
- rst  in  1  reset; synchronous, active-high.
- q_valid  in  1  query frame valid.
- q_ready  out  1  query frame accepted when q_valid && q_ready.
- q_frame  in  FRAME_WIDTH  query frame; frames arrive in order 0..NUM_FRAMES-1.
- frame_id  out  CLASS_W  class address to class_vec_gen.
- frame_index  out  FIDX_W  frame address to class_vec_gen.
- class_vec_in  in  FRAME_WIDTH  class frame returned combinationally by class_vec_gen, same cycle.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_class  out  CLASS_W  winning class id.
- res_dist  out  DIST_W  Hamming distance of the winner.

## Operation
- The FSM has three states: LOAD, SEARCH and DONE. Reset state is LOAD.
- LOAD:
  - q_ready=1.
  - Each accepted frame is stored at index load_cnt, then load_cnt increments.
  - On acceptance of frame NUM_FRAMES-1, the FSM moves to SEARCH. In the same transition it clears cls=0, fidx=0, acc=0, best_dist=all-ones and best_class=0.
  - Idle cycles (q_valid=0) are allowed anywhere in the sequence.
- SEARCH:
  - q_ready=0; frame_id=cls, frame_index=fidx.
  - Each cycle compute pop = popcount(qbuf[fidx] ^ class_vec_in), zero-extended to DIST_W.
  - If fidx<NUM_FRAMES-1: acc<=acc+pop, fidx++.
  - If fidx==NUM_FRAMES-1: dist=acc+pop.
    - If dist < best_dist (strict), then best_dist<=dist and best_class<=cls.
    - acc<=0, fidx<=0, cls++.
  - When cls==NUM_CLASSES-1 and fidx==NUM_FRAMES-1, the FSM moves to DONE. The final compare is applied in this same cycle.
- DONE:
  - res_valid=1, with res_class=best_class and res_dist=best_dist held stable.
  - On res_valid && res_ready, the FSM moves to LOAD and load_cnt is cleared.
- Ties resolve to the lowest class id, because of the strict compare and the ascending sweep.
- Outside SEARCH, frame_id=0 and frame_index=0.
- The query buffer is not cleared between queries; every query overwrites all NUM_FRAMES entries.

## Timing
- Reset values: q_ready=0 while rst=1, then 1 in the first cycle after rst deasserts. res_valid=0, res_class=0, res_dist=0, frame_id=0, frame_index=0. State=LOAD, load_cnt=0.
- Reset at any point (mid-load, mid-search, DONE with res_ready=0) aborts the operation. Partial data is discarded and no result is emitted.
- Search length is exactly NUM_CLASSES*NUM_FRAMES = 24 cycles.
- If the last query frame is accepted at edge T, SEARCH covers cycles T+1..T+24 and res_valid rises at T+25.
- Minimum query-to-query period is NUM_FRAMES + 24 + 1 cycles with res_ready held high.
- res_valid/res_class/res_dist stay constant while res_ready=0. A new query is not accepted until the handshake completes.
- q_valid is ignored outside LOAD.
- The ROM read is combinational. The pop+accumulate path completes in one cycle; no pipeline register is permitted on the address-to-data path.

## Test plan
- Query = class 0 frames 0..2 (from the class_vec_gen contents) -> res_class=0, res_dist=0, res_valid at T+25.
- Query = class 6 frames with bit 0 of frame 2 flipped -> res_class=6, res_dist=1.
- Query = class 3 frames, with q_valid gapped between frames for 5 cycles, then res_ready held low 10 cycles -> res_class=3, res_dist=0. Outputs stable across the stall; q_ready=0 until the handshake; q_ready=1 the cycle after.
- Tie: the bench computes a query equidistant from class 2 and class 5, with no other class closer -> res_class=2.
- rst asserted at SEARCH cycle 10 for 1 cycle -> res_valid never rises, all outputs 0, q_ready=1 after release. A following class 7 query -> res_class=7, res_dist=0.
- Back-to-back queries for classes 4 then 1 with res_ready=1 -> results (4,0) then (1,0). The second res_valid occurs 28 cycles after the first when the frames are supplied immediately.
